rel_cmp_scheduler: RTL and testbench

- Shares one 32-bit relational comparator between NUM_REQ requesters under round-robin arbitration.
- Sequences each granted compare through accept, execute and respond phases.
- Returns the boolean result, the z/n flags and the requester id over a valid/ready response channel.
- Sits between the control unit's issue logic and the relational compare datapath.

---
 rtl/rel_cmp_pkg.sv | 26 ++
 rtl/rel_cmp_core.sv | 41 ++++
 rtl/rel_cmp_scheduler.sv | 131 +++++++++++++
 tb/tb_rel_cmp_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rel_cmp_pkg.sv
// Shared types for the relational compare scheduler.
// Opcode and FSM state enums plus opcode signedness helper.
package rel_cmp_pkg;

  typedef enum logic [2:0] {
    OP_EQ  = 3'd0,
    OP_NE  = 3'd1,
    OP_LT  = 3'd2,
    OP_GT  = 3'd3,
    OP_LE  = 3'd4,
    OP_GE  = 3'd5,
    OP_LTU = 3'd6,
    OP_GEU = 3'd7
  } cmp_op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  function automatic logic op_is_signed(cmp_op_e op);
    return !(op == OP_LTU || op == OP_GEU);
  endfunction

endpackage

// File: rtl/rel_cmp_core.sv
// Combinational WIDTH-bit relational comparator.
// Direct compares only, so no overflow corner cases exist.
module rel_cmp_core
  import rel_cmp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  cmp_op_e          op,
  output logic             result,
  output logic             z,
  output logic             n
);

  logic eq;
  logic slt;
  logic ult;

  assign eq  = (a == b);
  assign slt = ($signed(a) < $signed(b));
  assign ult = (a < b);
  assign z   = eq;
  assign n   = op_is_signed(op) ? slt : ult;

  always_comb begin
    result = 1'b0;
    case (op)
      OP_EQ:   result = eq;
      OP_NE:   result = !eq;
      OP_LT:   result = slt;
      OP_GT:   result = !slt && !eq;
      OP_LE:   result = slt || eq;
      OP_GE:   result = !slt;
      OP_LTU:  result = ult;
      OP_GEU:  result = !ult;
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/rel_cmp_scheduler.sv
// Round-robin scheduler sharing one comparator among NUM_REQ requesters.
// Define REL_CMP_STATS_EN to build the saturating stat_count counter.
module rel_cmp_scheduler
  import rel_cmp_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]     req_op,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     rsp_result,
  output logic                     rsp_z,
  output logic                     rsp_n,
  output logic [31:0]              stat_count
);

  state_e            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   grant;
  logic [ID_W-1:0]   nxt_ptr;
  logic              any;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  cmp_op_e           op_q;
  logic [ID_W-1:0]   id_q;
  logic              c_result;
  logic              c_z;
  logic              c_n;

  // first valid index at or after rr_ptr, wrapping
  always_comb begin
    int j;
    j     = 0;
    any   = 1'b0;
    grant = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any && req_valid[j]) begin
        any   = 1'b1;
        grant = ID_W'(j);
      end
    end
  end

  assign nxt_ptr = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && any)
      req_ready[grant] = 1'b1;
  end

  rel_cmp_core #(.WIDTH(WIDTH)) u_core (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (c_result),
    .z      (c_z),
    .n      (c_n)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_EQ;
      id_q       <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= 1'b0;
      rsp_z      <= 1'b0;
      rsp_n      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            a_q    <= req_a[int'(grant)*WIDTH +: WIDTH];
            b_q    <= req_b[int'(grant)*WIDTH +: WIDTH];
            op_q   <= cmp_op_e'(req_op[int'(grant)*3 +: 3]);
            id_q   <= grant;
            rr_ptr <= nxt_ptr;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= c_result;
          rsp_z      <= c_z;
          rsp_n      <= c_n;
          rsp_id     <= id_q;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef REL_CMP_STATS_EN
  logic [31:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (rsp_valid && rsp_ready && cnt != '1)
      cnt <= cnt + 32'd1;
  end

  assign stat_count = cnt;
`else
  assign stat_count = 32'h0;
`endif

endmodule

// File: tb/tb_rel_cmp_scheduler.sv
// Scoreboard bench for rel_cmp_scheduler: directed cases plus random traffic.
// Expected responses come from a plain relational model of the opcodes.
module tb_rel_cmp_scheduler;

  localparam int N = 4;
  localparam int W = 32;
`ifdef REL_CMP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N*3-1:0] req_op;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic           rsp_result;
  logic           rsp_z;
  logic           rsp_n;
  logic [31:0]    stat_count;

  rel_cmp_scheduler #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_z      (rsp_z),
    .rsp_n      (rsp_n),
    .stat_count (stat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    bit result;
    bit z;
    bit n;
    int acc;
  } exp_t;

  exp_t       q[$];
  int         glog_id[$];
  int         glog_cyc[$];
  int         nchk = 0;
  int         nerr = 0;
  int         cyc = 0;
  int         model_ptr = 0;
  int         stats_exp = 0;
  int         last_xfer = 0;
  bit         seen = 1'b0;
  logic [N-1:0] taken = '0;
  logic       pv = 1'b0;
  logic       pr = 1'b0;
  logic [4:0] p_out = '0;
  int         l_id = -1;
  bit         l_res, l_z, l_n;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(int id, logic [31:0] a, logic [31:0] b,
                                 logic [2:0] op);
    exp_t e;
    e.id  = id;
    e.acc = 0;
    e.z   = (a == b);
    e.n   = (op >= 3'd6) ? (a < b) : ($signed(a) < $signed(b));
    case (op)
      3'd0:    e.result = (a == b);
      3'd1:    e.result = (a != b);
      3'd2:    e.result = ($signed(a) <  $signed(b));
      3'd3:    e.result = ($signed(a) >  $signed(b));
      3'd4:    e.result = ($signed(a) <= $signed(b));
      3'd5:    e.result = ($signed(a) >= $signed(b));
      3'd6:    e.result = (a < b);
      default: e.result = (a >= b);
    endcase
    return e;
  endfunction

  // monitor: predicts grants, pushes expectations, pops on response transfer
  always @(negedge clk) begin
    int g;
    int j;
    exp_t e;
    if (!rst_n) begin
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      if (req_ready != '0) begin
        g = -1;
        for (int k = 0; k < N; k++) begin
          j = (model_ptr + k) % N;
          if (g < 0 && req_valid[j]) g = j;
        end
        chk("grant", 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
        chk("ready_while_rsp", 64'(rsp_valid), 64'd0);
        if (g >= 0 && req_ready[g]) begin
          e = model(g, req_a[g*W +: W], req_b[g*W +: W], req_op[g*3 +: 3]);
          e.acc = cyc;
          q.push_back(e);
          model_ptr = (g + 1) % N;
          taken[g] = 1'b1;
          glog_id.push_back(g);
          glog_cyc.push_back(cyc);
        end
      end
      if (rsp_valid) begin
        if (q.size() == 0) begin
          chk("stale_rsp", 64'd1, 64'd0);
        end else begin
          if (!seen) begin
            chk("latency", 64'(cyc), 64'(q[0].acc + 2));
            seen = 1'b1;
          end else if (pv && !pr) begin
            chk("hold", 64'({rsp_id, rsp_result, rsp_z, rsp_n}), 64'(p_out));
          end
          if (rsp_ready) begin
            chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
            chk("rsp_result", 64'(rsp_result), 64'(q[0].result));
            chk("rsp_z", 64'(rsp_z), 64'(q[0].z));
            chk("rsp_n", 64'(rsp_n), 64'(q[0].n));
            chk("stat_count", 64'(stat_count), STATS ? 64'(stats_exp) : 64'd0);
            stats_exp++;
            l_id  = int'(rsp_id);
            l_res = rsp_result;
            l_z   = rsp_z;
            l_n   = rsp_n;
            last_xfer = cyc;
            void'(q.pop_front());
            seen = 1'b0;
          end
        end
      end
      pv    = rsp_valid;
      pr    = rsp_ready;
      p_out = {rsp_id, rsp_result, rsp_z, rsp_n};
    end
  end

  task automatic flush();
    q.delete();
    glog_id.delete();
    glog_cyc.delete();
    model_ptr = 0;
    stats_exp = 0;
    seen      = 1'b0;
    taken     = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (taken[k]) begin
        taken[k]     = 1'b0;
        req_valid[k] = 1'b0;
      end
    end
  endtask

  task automatic set_req(int i, logic [31:0] a, logic [31:0] b,
                         logic [2:0] op);
    req_valid[i]     = 1'b1;
    req_a[i*W +: W]  = a;
    req_b[i*W +: W]  = b;
    req_op[i*3 +: 3] = op;
  endtask

  task automatic drain();
    for (int t = 0; t < 300; t++) begin
      if (req_valid == '0 && q.size() == 0) return;
      step();
    end
    chk("drain_timeout", 64'd1, 64'd0);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'h7FFFFFFF;
      3:       return 32'h80000000;
      4:       return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n0;
    logic [31:0] ra;
    rst_n     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    #1 rst_n  = 1'b0;
    flush();
    for (int k = 0; k < N; k++) set_req(k, 32'(k), 32'h2, 3'(k));
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_stat", 64'(stat_count), 64'd0);
    chk("rst_outs", 64'({rsp_id, rsp_result, rsp_z, rsp_n}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // all requesters held valid: expect 0,1,2,3,0 spaced 3 cycles
    for (int t = 0; t < 40; t++) begin
      step();
      if (glog_id.size() >= 5) break;
      req_valid = '1;
    end
    req_valid = '0;
    chk("rr_count", 64'(glog_id.size() >= 5), 64'd1);
    if (glog_id.size() >= 5) begin
      for (int k = 0; k < 5; k++) begin
        chk("rr_order", 64'(glog_id[k]), 64'(k % 4));
        if (k > 0)
          chk("rr_spacing", 64'(glog_cyc[k] - glog_cyc[k-1]), 64'd3);
      end
    end
    drain();

    set_req(1, 32'h1, 32'h1, 3'd0);
    drain();
    chk("single", 64'({l_id[1:0], l_res, l_z, l_n}), 64'({2'd1, 3'b110}));

    set_req(0, 32'hFFFFFFFF, 32'h1, 3'd2);
    drain();
    chk("lt_signed", 64'({l_res, l_z, l_n}), 64'(3'b101));
    set_req(0, 32'hFFFFFFFF, 32'h1, 3'd6);
    drain();
    chk("ltu", 64'({l_res, l_z, l_n}), 64'(3'b000));

    // backpressure with a waiting requester
    rsp_ready = 1'b0;
    set_req(3, 32'h5, 32'h5, 3'd4);
    for (int t = 0; t < 10; t++) begin
      step();
      if (rsp_valid) break;
    end
    set_req(0, 32'h7, 32'h3, 3'd3);
    for (int t = 0; t < 5; t++) begin
      step();
      chk("bp_ready", 64'(req_ready), 64'd0);
      chk("bp_valid", 64'(rsp_valid), 64'd1);
    end
    n0 = glog_id.size();
    rsp_ready = 1'b1;
    step();
    step();
    chk("bp_accept", 64'(glog_id.size()), 64'(n0 + 1));
    if (glog_id.size() > n0) begin
      chk("bp_idle_next", 64'(glog_cyc[$] - last_xfer), 64'd1);
      chk("bp_next_id", 64'(glog_id[$]), 64'd0);
    end
    drain();
    chk("stats_mid", 64'(stat_count), STATS ? 64'(stats_exp) : 64'd0);

    // reset while a compare is in EXEC
    set_req(2, 32'h9, 32'h9, 3'd0);
    n0 = glog_id.size();
    for (int t = 0; t < 10; t++) begin
      step();
      if (glog_id.size() > n0) break;
    end
    set_req(0, 32'h3, 32'h4, 3'd7);
    #2 rst_n = 1'b0;
    flush();
    #1;
    chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    chk("mid_rst_stat", 64'(stat_count), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    set_req(3, 32'h80000000, 32'h7FFFFFFF, 3'd5);
    drain();
    chk("post_rst_first", 64'(glog_id.size() > 0 ? glog_id[0] : -1), 64'd0);
    set_req(1, 32'hA, 32'hB, 3'd1);
    drain();
    chk("stats_three", 64'(stat_count), STATS ? 64'd3 : 64'd0);

    // random traffic
    for (int t = 0; t < 600; t++) begin
      step();
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) begin
        if (!req_valid[k] && !taken[k] && $urandom_range(0, 2) == 0) begin
          ra = rnd_val();
          set_req(k, ra, ($urandom_range(0, 3) == 0) ? ra : rnd_val(),
                  3'($urandom_range(0, 7)));
        end
      end
    end
    rsp_ready = 1'b1;
    drain();
    chk("stats_final", 64'(stat_count), STATS ? 64'(stats_exp) : 64'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
